ofm_write_ctrl: RTL
===================

OFM_WRITE_CTRL -- requirements
Module: ofm_write_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning number of 32-bit OFM words; address wraps modulo DEPTH.
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a layer write-out.
REQ-006 SHALL have port base_addr  input  AW  first word address; sampled on start.
REQ-007 SHALL have port word_count  input  32  number of words to write; sampled on start.
REQ-008 SHALL have ports req0_valid/req1_valid  input  1 each  requester byte valid.
REQ-009 SHALL have ports req0_data/req1_data  input  8 each  requester result byte.
REQ-010 SHALL have ports req0_ready/req1_ready  output  1 each  byte accepted this cycle.
REQ-011 SHALL have port address  output  AW  OFM write address.
REQ-012 SHALL have port wr_data  output  32  packed word; first accepted byte in [31:24], last in [7:0].
REQ-013 SHALL have port wr  output  1  OFM write strobe, one cycle per word.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  level; high in DONE.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DONE: IDLE/DONE --start--> RUN (or DONE if word_count==0); RUN --last word written--> DONE.
REQ-017 SHALL ignore start while in RUN.
REQ-018 SHALL assert reqN_ready only in RUN, same cycle as reqN_valid, for at most one requester per cycle (combinational grant).
REQ-019 SHALL arbitrate round-robin: with both valid, grant the requester not granted most recently; pointer favours req0 after reset and on each start.
REQ-020 SHALL place accepted bytes into a pack register at byte index 0..3, index incrementing per accepted byte and wrapping 3->0.
REQ-021 SHALL assert wr exactly one cycle after the cycle in which byte index 3 is accepted, with wr_data = packed word and address = (base_addr + word_idx) mod DEPTH.
REQ-022 SHALL keep wr_data/address registered so a new byte may be accepted in the same cycle wr is high without corrupting the written word.
REQ-023 SHALL increment word_idx on each wr; in the wr cycle where word_idx == word_count-1 the FSM SHALL enter DONE and deassert all ready from that cycle on.
REQ-024 SHALL hold done high until the next start or reset; busy = (state==RUN).
REQ-025 SHALL drop no accepted byte and accept none once word_count bytes*4 are accepted.

Reset
REQ-026 SHALL, on rst_n low (any time, including mid-word), force IDLE, byte index 0, word_idx 0, pointer to req0, and outputs wr=0, done=0, busy=0, ready=0, address=0, wr_data=0.
REQ-027 SHALL discard any partial word on reset; no wr is issued for it.

Configuration
REQ-028 SHALL, with macro OFM_CTRL_FLUSH_EN defined, add input flush (1 bit): in RUN with byte index !=0, the next cycle issues wr of the partial word zero-padded in the unfilled low bytes, counting as one word.
REQ-029 SHALL, without OFM_CTRL_FLUSH_EN, omit the flush port; partial words are written only when completed.

Verification
REQ-030 SHALL cover: base_addr=0, word_count=2, req0 sends 8'h01..8'h08 -> wr at addr 0 data 32'h01020304, addr 1 data 32'h05060708, done=1.
REQ-031 SHALL cover: both valid every cycle, req0 bytes AA, req1 bytes BB -> wr_data 32'hAABBAABB; grants alternate.
REQ-032 SHALL cover: base_addr=127, word_count=2 -> writes at addresses 127 then 0.
REQ-033 SHALL cover: word_count=0 start -> done=1 next cycle, no wr, no ready.
REQ-034 SHALL cover: rst_n low after 2 bytes accepted -> no wr, all outputs 0; fresh start yields correct first word at base_addr.
REQ-035 SHALL cover (OFM_CTRL_FLUSH_EN): bytes 11,22 then flush -> wr_data 32'h11220000.

Source files
------------

// File: rtl/ofm_write_ctrl.sv
// ofm_write_ctrl
//   Collects result bytes from two requesters and packs them, first byte in
//   the MSB, into 32-bit OFM words. Each completed word is written to
//   (base_addr + word_idx) mod DEPTH. A layer write-out begins with a start
//   pulse and ends in DONE after word_count words.
//
//   Optional feature: define OFM_CTRL_FLUSH_EN to add a 'flush' input. It
//   writes out a partially filled word, zero-padded in the low bytes.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a write-out (ignored while busy)
//   base_addr, word_count first word address / number of words, sampled on start
//   req0_*/req1_*         byte requesters (valid/data in, ready out)
//   flush                 (OFM_CTRL_FLUSH_EN only) write the partial word now
//   address, wr_data, wr  registered OFM write port
//   busy, done            status levels
module ofm_write_ctrl #(
    parameter int DEPTH = 128,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [31:0]   word_count,
    input  logic          req0_valid,
    input  logic [7:0]    req0_data,
    input  logic          req1_valid,
    input  logic [7:0]    req1_data,
`ifdef OFM_CTRL_FLUSH_EN
    input  logic          flush,
`endif
    output logic          req0_ready,
    output logic          req1_ready,
    output logic [AW-1:0] address,
    output logic [31:0]   wr_data,
    output logic          wr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int SW = ((AW > 32) ? AW : 32) + 1;

    state_t        state, state_nxt;
    logic [AW-1:0] base_r;
    logic [31:0]   count_r;
    logic [31:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   pack;
    logic          rr_ptr;      // 0: req0 wins a tie, 1: req1 wins a tie

    logic          run, g0, g1, acc;
    logic [7:0]    acc_byte;
    logic [4:0]    lsb;
    logic [31:0]   pack_nxt;
    logic          flush_fire, word_done, last_word;
    logic [SW-1:0] sum;
    logic [AW-1:0] addr_nxt;

    always_comb begin
        run      = (state == RUN);
        g0       = run & req0_valid & (~req1_valid | ~rr_ptr);
        g1       = run & req1_valid & (~req0_valid |  rr_ptr);
        acc      = g0 | g1;
        acc_byte = g0 ? req0_data : req1_data;

        // byte index 0 lands in [31:24], index 3 in [7:0]
        lsb      = {~byte_idx, 3'b000};
        pack_nxt = pack;
        if (acc) pack_nxt[lsb +: 8] = acc_byte;

`ifdef OFM_CTRL_FLUSH_EN
        flush_fire = run & flush & (byte_idx != 2'd0);
`else
        flush_fire = 1'b0;
`endif
        word_done = (acc && byte_idx == 2'd3) || flush_fire;
        last_word = word_done && (word_idx == count_r - 32'd1);

        sum      = SW'(base_r) + SW'(word_idx);
        addr_nxt = AW'(sum % SW'(DEPTH));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (word_count == 32'd0) ? DONE : RUN;
            RUN:        if (last_word) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign req0_ready = g0;
    assign req1_ready = g1;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_r   <= '0;
            count_r  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            pack     <= '0;
            rr_ptr   <= 1'b0;
            address  <= '0;
            wr_data  <= '0;
            wr       <= 1'b0;
        end else begin
            state <= state_nxt;
            wr    <= word_done;
            if (start && state != RUN) begin
                base_r   <= base_addr;
                count_r  <= word_count;
                word_idx <= '0;
                byte_idx <= '0;
                pack     <= '0;
                rr_ptr   <= 1'b0;
            end else if (run) begin
                if (g0)      rr_ptr <= 1'b1;
                else if (g1) rr_ptr <= 1'b0;
                if (word_done) begin
                    // pack clears so unfilled bytes of the next word stay zero
                    wr_data  <= pack_nxt;
                    address  <= addr_nxt;
                    pack     <= '0;
                    byte_idx <= '0;
                    word_idx <= word_idx + 32'd1;
                end else if (acc) begin
                    pack     <= pack_nxt;
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule
